// File: rtl/hdmi_rx_pkg.sv
// rtl/hdmi_rx_pkg.sv - shared types and constants for the HDMI sink packet path
package hdmi_rx_pkg;

  localparam logic [7:0] PKT_NULL         = 8'h00;
  localparam logic [7:0] PKT_ACR          = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] PKT_AVI          = 8'h82;
  localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

  localparam int IEC_BLOCK_FRAMES = 192;

  // Samples travel at full subpacket width; the top keeps the MSBs it needs.
  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
    logic        block_start;
  } stereo_sample_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } sorter_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous first-word-fall-through FIFO for stereo samples
module audio_sample_fifo #(
  parameter int  FIFO_DEPTH = 8,
  parameter type T          = logic [7:0]
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_data,
  output logic o_push_ok,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T            r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  assign o_push_ok = i_push && (!o_full || i_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/packet_sorter.sv
// rtl/packet_sorter.sv - HDMI sink data-island packet dispatcher (audio FIFO, ACR, InfoFrames)
// Optional InfoFrame checksum gating: define INFOFRAME_CHECKSUM_EN.
module packet_sorter
  import hdmi_rx_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 24,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                         clk_pixel,
  input  logic                         reset_n,
  input  logic                         packet_valid,
  input  logic                         packet_ecc_error,
  input  logic [23:0]                  header,
  input  logic [3:0][55:0]             sub,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [2*AUDIO_BIT_WIDTH-1:0] sample_word,
  output logic                         sample_block_start,
  output logic [19:0]                  acr_n,
  output logic [19:0]                  acr_cts,
  output logic                         acr_update,
  output logic [6:0]                   video_id_code,
  output logic [2:0]                   audio_channel_count,
  output logic [39:0]                  channel_status,
  output logic                         overflow,
  output logic [7:0]                   dropped_count
);

  sorter_state_t r_state, w_state_next;
  logic [1:0]    r_idx, w_idx_next;
  logic [3:0]    r_hb1;
  logic [3:0]    r_hb2;
  logic [3:0][50:0] r_sub;

  logic [19:0] r_acr_n, r_acr_cts;
  logic        r_acr_update;
  logic [6:0]  r_vic;
  logic [2:0]  r_chan_cnt;
  logic [39:0] r_cs, r_cs_shadow;
  logic [7:0]  r_cs_pos;
  logic        r_overflow;
  logic [7:0]  r_dropped;
  logic [2*AUDIO_BIT_WIDTH-1:0] r_hold_word;

  logic w_accept, w_do_acr, w_do_avi, w_do_ainfo, w_do_drop, w_start;
  logic w_csum_ok;
  logic w_push, w_push_ok, w_pop, w_fifo_empty, w_fifo_full;
  logic [7:0] w_cs_pos;
  stereo_sample_t w_push_data, w_head;
  logic [2*AUDIO_BIT_WIDTH-1:0] w_head_word;

`ifdef INFOFRAME_CHECKSUM_EN
  logic [7:0] w_csum;
  always_comb begin
    w_csum = header[7:0] + header[15:8] + header[23:16];
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 7; b++) begin
        w_csum = w_csum + sub[s][8*b +: 8];
      end
    end
  end
  assign w_csum_ok = (w_csum == 8'h00);
`else
  assign w_csum_ok = 1'b1;
`endif

  assign w_accept = packet_valid && (r_state == ST_IDLE);

  always_comb begin
    w_do_acr   = 1'b0;
    w_do_avi   = 1'b0;
    w_do_ainfo = 1'b0;
    w_do_drop  = 1'b0;
    w_start    = 1'b0;
    if (w_accept) begin
      if (packet_ecc_error) begin
        w_do_drop = 1'b1;
      end else begin
        case (header[7:0])
          PKT_NULL:         ;
          PKT_ACR:          w_do_acr = 1'b1;
          PKT_AVI:          if (w_csum_ok) w_do_avi = 1'b1; else w_do_drop = 1'b1;
          PKT_AUDIO_INFO:   if (w_csum_ok) w_do_ainfo = 1'b1; else w_do_drop = 1'b1;
          PKT_AUDIO_SAMPLE: if (header[12]) w_do_drop = 1'b1; else w_start = 1'b1;
          default:          w_do_drop = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_UNPACK;
          w_idx_next   = 2'd0;
        end
      end
      ST_UNPACK: begin
        w_idx_next = r_idx + 2'd1;
        if (r_idx == 2'd3) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  assign w_push                  = (r_state == ST_UNPACK) && r_hb1[r_idx];
  assign w_push_data.left        = r_sub[r_idx][23:0];
  assign w_push_data.right       = r_sub[r_idx][47:24];
  assign w_push_data.block_start = r_hb2[r_idx];
  assign w_cs_pos                = r_hb2[r_idx] ? 8'd0 : r_cs_pos;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_hb1        <= '0;
      r_hb2        <= '0;
      r_sub        <= '0;
      r_acr_n      <= '0;
      r_acr_cts    <= '0;
      r_acr_update <= 1'b0;
      r_vic        <= '0;
      r_chan_cnt   <= '0;
      r_cs         <= '0;
      r_cs_shadow  <= '0;
      r_cs_pos     <= '0;
      r_overflow   <= 1'b0;
      r_dropped    <= '0;
      r_hold_word  <= '0;
    end else begin
      r_acr_update <= w_do_acr;
      if (w_start) begin
        r_hb1 <= header[11:8];
        r_hb2 <= header[23:20];
        r_sub <= {sub[3][50:0], sub[2][50:0], sub[1][50:0], sub[0][50:0]};
      end
      if (w_do_acr) begin
        r_acr_cts <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
        r_acr_n   <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
      end
      if (w_do_avi)   r_vic      <= sub[0][38:32];
      if (w_do_ainfo) r_chan_cnt <= sub[0][10:8];
      if (w_do_drop && (r_dropped != 8'hFF)) r_dropped <= r_dropped + 8'd1;
      if ((packet_valid && (r_state == ST_UNPACK)) || (w_push && !w_push_ok)) r_overflow <= 1'b1;
      // Channel status tracks every unpacked frame, even ones the full FIFO loses.
      if (w_push) begin
        if (w_cs_pos < 8'd40) r_cs_shadow[w_cs_pos[5:0]] <= r_sub[r_idx][50];
        if (w_cs_pos == 8'(IEC_BLOCK_FRAMES - 1)) begin
          r_cs     <= r_cs_shadow;
          r_cs_pos <= 8'd0;
        end else begin
          r_cs_pos <= w_cs_pos + 8'd1;
        end
      end
      if (w_pop) r_hold_word <= w_head_word;
    end
  end

  audio_sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (stereo_sample_t)
  ) u_fifo (
    .i_clk     (clk_pixel),
    .i_rst_n   (reset_n),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .o_push_ok (w_push_ok),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign w_pop       = !w_fifo_empty && sample_ready;
  assign w_head_word = {w_head.right[23 -: AUDIO_BIT_WIDTH], w_head.left[23 -: AUDIO_BIT_WIDTH]};

  assign sample_valid        = !w_fifo_empty;
  assign sample_word         = w_fifo_empty ? r_hold_word : w_head_word;
  assign sample_block_start  = !w_fifo_empty && w_head.block_start;
  assign acr_n               = r_acr_n;
  assign acr_cts             = r_acr_cts;
  assign acr_update          = r_acr_update;
  assign video_id_code       = r_vic;
  assign audio_channel_count = r_chan_cnt;
  assign channel_status      = r_cs;
  assign overflow            = r_overflow;
  assign dropped_count       = r_dropped;

  logic w_unused;
  assign w_unused = ^{header, sub, r_sub, w_head, w_fifo_full};

endmodule

// File: tb/tb_packet_sorter.sv
// tb/tb_packet_sorter.sv - directed self-checking bench for packet_sorter
module tb_packet_sorter;

`ifdef INFOFRAME_CHECKSUM_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  logic             clk_pixel = 1'b0;
  logic             reset_n;
  logic             packet_valid;
  logic             packet_ecc_error;
  logic [23:0]      header;
  logic [3:0][55:0] sub_in;
  logic             sample_valid;
  logic             sample_ready;
  logic [31:0]      sample_word;
  logic             sample_block_start;
  logic [19:0]      acr_n, acr_cts;
  logic             acr_update;
  logic [6:0]       video_id_code;
  logic [2:0]       audio_channel_count;
  logic [39:0]      channel_status;
  logic             overflow;
  logic [7:0]       dropped_count;

  int n_checks = 0;
  int n_errors = 0;

  packet_sorter #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk_pixel           (clk_pixel),
    .reset_n             (reset_n),
    .packet_valid        (packet_valid),
    .packet_ecc_error    (packet_ecc_error),
    .header              (header),
    .sub                 (sub_in),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
    .sample_word         (sample_word),
    .sample_block_start  (sample_block_start),
    .acr_n               (acr_n),
    .acr_cts             (acr_cts),
    .acr_update          (acr_update),
    .video_id_code       (video_id_code),
    .audio_channel_count (audio_channel_count),
    .channel_status      (channel_status),
    .overflow            (overflow),
    .dropped_count       (dropped_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [23:0] hdr;
    logic [55:0] s0;
    logic        ecc;
    logic        upd;
    logic [19:0] cts;
    logic [19:0] n;
    logic [6:0]  vic;
    logic [2:0]  acc;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk_left(input int p, input int i);
    return 24'h123456 + {4'(p), 4'(i), 16'h0000};
  endfunction

  function automatic logic [23:0] mk_right(input int p, input int i);
    return 24'hABCDEF + {4'(p), 4'(i), 16'h0000};
  endfunction

  function automatic logic [31:0] exp_word(input int p, input int i);
    logic [23:0] l, r;
    l = mk_left(p, i);
    r = mk_right(p, i);
    return {r[23:8], l[23:8]};
  endfunction

  function automatic logic [55:0] mk_sub(input logic [23:0] l, input logic [23:0] r, input logic c);
    return {5'b0, c, 2'b0, r, l};
  endfunction

  task automatic send(input logic [23:0] hdr, input logic [55:0] s0, input logic [55:0] s1,
                      input logic [55:0] s2, input logic [55:0] s3, input logic ecc);
    @(posedge clk_pixel); #1;
    header           = hdr;
    sub_in           = {s3, s2, s1, s0};
    packet_ecc_error = ecc;
    packet_valid     = 1'b1;
    @(posedge clk_pixel); #1;
    packet_valid     = 1'b0;
    packet_ecc_error = 1'b0;
  endtask

  task automatic send_audio(input int p, input logic [7:0] hb1, input logic [7:0] hb2, input logic [3:0] c);
    send({hb2, hb1, 8'h02},
         mk_sub(mk_left(p, 0), mk_right(p, 0), c[0]),
         mk_sub(mk_left(p, 1), mk_right(p, 1), c[1]),
         mk_sub(mk_left(p, 2), mk_right(p, 2), c[2]),
         mk_sub(mk_left(p, 3), mk_right(p, 3), c[3]), 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] cbits;

    vecs[0] = '{24'h000001, {8'h00,8'h18,8'h00,8'hA0,8'h86,8'h01,8'h00}, 1'b0, 1'b1, 20'h186A0, 20'h01800, 7'd0,  3'd0, 8'd0};
    vecs[1] = '{24'h000001, {8'h55,8'h22,8'h03,8'h11,8'h22,8'h03,8'h00}, 1'b1, 1'b0, 20'h186A0, 20'h01800, 7'd0,  3'd0, 8'd1};
    vecs[2] = '{24'h0D0282, {8'h00,8'h00,8'h10,8'h00,8'h00,8'h00,8'h5F}, 1'b0, 1'b0, 20'h186A0, 20'h01800, 7'd16, 3'd0, 8'd1};
    vecs[3] = '{24'h0D0282, {8'h00,8'h00,8'h10,8'h00,8'h00,8'h00,8'h60}, 1'b0, 1'b0, 20'h186A0, 20'h01800, 7'd16, 3'd0, 8'(1 + CS_EN)};
    vecs[4] = '{24'h0D0282, {8'h00,8'h00,8'h04,8'h00,8'h00,8'h00,8'h6C}, 1'b0, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd0, 8'(1 + 2*CS_EN)};
    vecs[5] = '{24'h0A0184, {8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'h70}, 1'b0, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd1, 8'(1 + 2*CS_EN)};
    vecs[6] = '{24'h123400, {8'h77,8'h66,8'h55,8'h44,8'h33,8'h22,8'h11}, 1'b0, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd1, 8'(1 + 2*CS_EN)};
    vecs[7] = '{24'h000083, {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1'b0, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd1, 8'(2 + 2*CS_EN)};
    vecs[8] = '{24'h101F02, {8'h00,8'h00,8'hAB,8'hCD,8'h12,8'h34,8'h56}, 1'b0, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd1, 8'(3 + 2*CS_EN)};
    vecs[9] = '{24'h0A0184, {8'h00,8'h00,8'h00,8'h00,8'h00,8'h05,8'h70}, 1'b1, 1'b0, 20'h186A0, 20'h01800,
                (CS_EN != 0) ? 7'd16 : 7'd4, 3'd1, 8'(4 + 2*CS_EN)};

    packet_valid = 1'b0; packet_ecc_error = 1'b0; header = '0; sub_in = '0; sample_ready = 1'b0;
    do_reset();

    @(negedge clk_pixel);
    check("rst_valid", sample_valid, 0);
    check("rst_word", sample_word, 0);
    check("rst_bstart", sample_block_start, 0);
    check("rst_acr", {acr_n, acr_cts, acr_update}, 0);
    check("rst_vic_acc", {video_id_code, audio_channel_count}, 0);
    check("rst_cs", channel_status, 0);
    check("rst_ovf_drop", {overflow, dropped_count}, 0);

    // Audio latency and ordering, ready held high.
    sample_ready = 1'b1;
    send_audio(0, 8'h0F, 8'h10, 4'b0000);
    @(negedge clk_pixel);
    check("aud_lat1_valid", sample_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_pixel);
      check($sformatf("aud_s%0d_valid", i), sample_valid, 1);
      check($sformatf("aud_s%0d_word", i), sample_word, exp_word(0, i));
      check($sformatf("aud_s%0d_b", i), sample_block_start, (i == 0) ? 1 : 0);
    end
    @(negedge clk_pixel);
    check("aud_empty", sample_valid, 0);
    check("aud_hold_word", sample_word, exp_word(0, 3));
    check("aud_no_ovf", overflow, 0);

    // Packet arriving while unpacking is discarded.
    do_reset();
    send_audio(0, 8'h0F, 8'h10, 4'b0000);
    send(24'h000001, {8'h00,8'h18,8'h00,8'hA0,8'h86,8'h01,8'h00}, '0, '0, '0, 1'b0);
    check("busy_no_upd", acr_update, 0);
    check("busy_cts", acr_cts, 0);
    check("busy_ovf", overflow, 1);
    check("busy_drop", dropped_count, 0);
    repeat (6) @(posedge clk_pixel);

    // FIFO overflow with consumer stalled.
    do_reset();
    sample_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send_audio(p, 8'h0F, 8'h00, 4'b0000);
      repeat (3) @(posedge clk_pixel);
    end
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("ovf_valid", sample_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", dropped_count, 0);
    sample_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (sample_valid) begin
        cnt++;
        if (cnt == 1) check("ovf_first", sample_word, exp_word(0, 0));
        if (cnt == 8) check("ovf_last", sample_word, exp_word(1, 3));
      end
      @(negedge clk_pixel);
    end
    check("ovf_count", cnt, 8);

    // Channel status over one full 192-frame block.
    do_reset();
    for (int p = 0; p < 48; p++) begin
      for (int i = 0; i < 4; i++) cbits[i] = ((4*p + i) == 1) || ((4*p + i) == 25);
      if (p == 47) begin
        @(negedge clk_pixel);
        check("cs_before_end", channel_status, 0);
      end
      send_audio(p, 8'h0F, (p == 0) ? 8'h10 : 8'h00, cbits);
      repeat (3) @(posedge clk_pixel);
    end
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("cs_block", channel_status, 40'h00_0200_0002);
    check("cs_no_ovf", overflow, 0);

    // Single-cycle packet types.
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].hdr, vecs[v].s0, 56'h0, 56'h0, 56'h0, vecs[v].ecc);
      check($sformatf("v%0d_upd", v), acr_update, vecs[v].upd);
      repeat (3) @(posedge clk_pixel);
      @(negedge clk_pixel);
      check($sformatf("v%0d_upd_off", v), acr_update, 0);
      check($sformatf("v%0d_cts", v), acr_cts, vecs[v].cts);
      check($sformatf("v%0d_n", v), acr_n, vecs[v].n);
      check($sformatf("v%0d_vic", v), video_id_code, vecs[v].vic);
      check($sformatf("v%0d_acc", v), audio_channel_count, vecs[v].acc);
      check($sformatf("v%0d_drop", v), dropped_count, vecs[v].drop);
      check($sformatf("v%0d_nosample", v), sample_valid, 0);
    end

    // dropped_count saturates.
    for (int k = 0; k < 260; k++) send(24'h000083, '0, '0, '0, '0, 1'b0);
    @(negedge clk_pixel);
    check("drop_sat", dropped_count, 8'hFF);

    // Reset in the middle of an unpack.
    sample_ready = 1'b0;
    send_audio(5, 8'h0F, 8'h10, 4'b1111);
    @(posedge clk_pixel); #1;
    check("mid_pushed", sample_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_word", sample_word, 0);
    check("mid_rst_cs", channel_status, 0);
    check("mid_rst_drop", dropped_count, 0);
    check("mid_rst_misc", {acr_n, acr_cts, video_id_code, audio_channel_count, overflow}, 0);
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("mid_after_valid", sample_valid, 0);
    check("mid_after_ovf", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
